// File: rtl/cache_stats_pkg.sv
// rtl/cache_stats_pkg.sv - shared types and defaults for the cache statistics counters
package cache_stats_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_t;

  typedef struct packed {
    logic valid;
    logic miss;
    logic conflict;
  } cache_evt_t;

  localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter with sticky overflow, saturating or wrapping
module sat_counter #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // clr has priority so a same-cycle increment is dropped
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (cnt == CNT_MAX) begin
        ovf <= 1'b1;
        cnt <= SATURATE ? CNT_MAX : '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_event_counter.sv
// rtl/cache_event_counter.sv - per-cache access/miss/conflict counters with req/ack snapshot
module cache_event_counter
  import cache_stats_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter bit SATURATE = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             evt_valid,
  input  logic             evt_miss,
  input  logic             evt_conflict,
  input  logic             freeze,
  input  logic             clear,
  input  logic             snap_req,
  output logic             snap_ack,
  output logic [CNT_W-1:0] access_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic [CNT_W-1:0] snap_access,
  output logic [CNT_W-1:0] snap_miss,
  output logic [CNT_W-1:0] snap_conflict,
  output logic [2:0]       ovf,
  output logic             proto_err
);

  cache_evt_t  evt;
  logic        inc_access;
  logic        inc_miss;
  logic        inc_conflict;
  logic        bad_evt;
  snap_state_t state;
  snap_state_t state_next;
  logic        capture;

  assign evt = '{valid: evt_valid, miss: evt_miss, conflict: evt_conflict};

  // a conflict without a miss is a controller bug: count the access only
  assign inc_access   = !freeze && evt.valid;
  assign inc_miss     = !freeze && evt.valid && evt.miss;
  assign inc_conflict = !freeze && evt.valid && evt.miss && evt.conflict;
  assign bad_evt      = !freeze && evt.valid && evt.conflict && !evt.miss;

  sat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_access (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (inc_access),
    .clr  (clear),
    .cnt  (access_cnt),
    .ovf  (ovf[0])
  );

  sat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_miss (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (inc_miss),
    .clr  (clear),
    .cnt  (miss_cnt),
    .ovf  (ovf[1])
  );

  sat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_conflict (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (inc_conflict),
    .clr  (clear),
    .cnt  (conflict_cnt),
    .ovf  (ovf[2])
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      proto_err <= 1'b0;
    end else if (clear) begin
      proto_err <= 1'b0;
    end else if (bad_evt) begin
      proto_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    snap_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (snap_req) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        snap_ack = 1'b1;
        if (!snap_req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // captures pre-update values, so a same-cycle clear does not affect the copy
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      snap_access   <= '0;
      snap_miss     <= '0;
      snap_conflict <= '0;
    end else if (capture) begin
      snap_access   <= access_cnt;
      snap_miss     <= miss_cnt;
      snap_conflict <= conflict_cnt;
    end
  end

endmodule

// File: tb/tb_cache_event_counter.sv
// tb/tb_cache_event_counter.sv - table-driven bench for cache_event_counter
module tb_cache_event_counter;

  logic        CLK;
  logic        nRST;
  logic        evt_valid, evt_miss, evt_conflict, freeze, clear, snap_req;

  logic        snap_ack;
  logic [31:0] access_cnt, miss_cnt, conflict_cnt;
  logic [31:0] snap_access, snap_miss, snap_conflict;
  logic [2:0]  ovf;
  logic        proto_err;

  logic        s4_ack, s4_perr, w4_ack, w4_perr;
  logic [3:0]  s4_acc, s4_miss, s4_conf, s4_sacc, s4_smiss, s4_sconf;
  logic [3:0]  w4_acc, w4_miss, w4_conf, w4_sacc, w4_smiss, w4_sconf;
  logic [2:0]  s4_ovf, w4_ovf;

  int checks = 0;
  int errors = 0;

  cache_event_counter #(.CNT_W(32), .SATURATE(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .evt_valid(evt_valid), .evt_miss(evt_miss),
    .evt_conflict(evt_conflict), .freeze(freeze), .clear(clear), .snap_req(snap_req),
    .snap_ack(snap_ack), .access_cnt(access_cnt), .miss_cnt(miss_cnt),
    .conflict_cnt(conflict_cnt), .snap_access(snap_access), .snap_miss(snap_miss),
    .snap_conflict(snap_conflict), .ovf(ovf), .proto_err(proto_err)
  );

  cache_event_counter #(.CNT_W(4), .SATURATE(1'b1)) u_sat4 (
    .CLK(CLK), .nRST(nRST), .evt_valid(evt_valid), .evt_miss(evt_miss),
    .evt_conflict(evt_conflict), .freeze(freeze), .clear(clear), .snap_req(snap_req),
    .snap_ack(s4_ack), .access_cnt(s4_acc), .miss_cnt(s4_miss),
    .conflict_cnt(s4_conf), .snap_access(s4_sacc), .snap_miss(s4_smiss),
    .snap_conflict(s4_sconf), .ovf(s4_ovf), .proto_err(s4_perr)
  );

  cache_event_counter #(.CNT_W(4), .SATURATE(1'b0)) u_wrap4 (
    .CLK(CLK), .nRST(nRST), .evt_valid(evt_valid), .evt_miss(evt_miss),
    .evt_conflict(evt_conflict), .freeze(freeze), .clear(clear), .snap_req(snap_req),
    .snap_ack(w4_ack), .access_cnt(w4_acc), .miss_cnt(w4_miss),
    .conflict_cnt(w4_conf), .snap_access(w4_sacc), .snap_miss(w4_smiss),
    .snap_conflict(w4_sconf), .ovf(w4_ovf), .proto_err(w4_perr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic v, m, c, f, clr;
    int   ea, em, ec;
    logic ep;
  } vec_t;

  vec_t vt[25];

  function automatic vec_t mk(logic v, logic m, logic c, logic f, logic clr,
                              int ea, int em, int ec, logic ep);
    vec_t r;
    r.v = v; r.m = m; r.c = c; r.f = f; r.clr = clr;
    r.ea = ea; r.em = em; r.ec = ec; r.ep = ep;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // inputs change at negedge; results are read at the following negedge
  task automatic cyc(input logic v, input logic m, input logic c, input logic f, input logic clr);
    evt_valid = v; evt_miss = m; evt_conflict = c; freeze = f; clear = clr;
    @(posedge CLK);
    @(negedge CLK);
    evt_valid = 1'b0; evt_miss = 1'b0; evt_conflict = 1'b0; freeze = 1'b0; clear = 1'b0;
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cyc(vt[i].v, vt[i].m, vt[i].c, vt[i].f, vt[i].clr);
      chk($sformatf("vec%0d access", i), access_cnt, vt[i].ea);
      chk($sformatf("vec%0d miss", i), miss_cnt, vt[i].em);
      chk($sformatf("vec%0d conflict", i), conflict_cnt, vt[i].ec);
      chk($sformatf("vec%0d proto_err", i), {31'd0, proto_err}, {31'd0, vt[i].ep});
      chk($sformatf("vec%0d ovf", i), {29'd0, ovf}, 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " snap_ack"}, {31'd0, snap_ack}, 32'd0);
    chk({tag, " access"}, access_cnt, 32'd0);
    chk({tag, " miss"}, miss_cnt, 32'd0);
    chk({tag, " conflict"}, conflict_cnt, 32'd0);
    chk({tag, " snap_access"}, snap_access, 32'd0);
    chk({tag, " snap_miss"}, snap_miss, 32'd0);
    chk({tag, " snap_conflict"}, snap_conflict, 32'd0);
    chk({tag, " ovf"}, {29'd0, ovf}, 32'd0);
    chk({tag, " proto_err"}, {31'd0, proto_err}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) vt[i] = mk(1, 0, 0, 0, 0, i + 1, 0, 0, 0);
    vt[5]  = mk(1, 1, 1, 0, 0, 6, 1, 1, 0);
    vt[6]  = mk(1, 1, 1, 0, 0, 7, 2, 2, 0);
    vt[7]  = mk(1, 1, 0, 0, 0, 8, 3, 2, 0);
    vt[8]  = mk(0, 1, 1, 0, 0, 8, 3, 2, 0);
    vt[9]  = mk(1, 1, 1, 0, 0, 1, 1, 1, 0);
    vt[10] = mk(1, 1, 0, 0, 0, 2, 2, 1, 0);
    for (int i = 11; i < 15; i++) vt[i] = mk(1, 0, 0, 0, 0, i - 8, 2, 1, 0);
    vt[15] = mk(1, 1, 0, 0, 1, 0, 0, 0, 0);
    vt[16] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[17] = mk(1, 0, 1, 0, 0, 2, 0, 0, 1);
    for (int i = 18; i < 22; i++) vt[i] = mk(1, 1, 0, 1, 0, 2, 0, 0, 1);
    vt[22] = mk(1, 0, 1, 1, 0, 2, 0, 0, 1);
    vt[23] = mk(1, 1, 0, 1, 1, 0, 0, 0, 0);
    vt[24] = mk(1, 1, 1, 0, 0, 1, 1, 1, 0);

    nRST = 1'b0; snap_req = 1'b0;
    evt_valid = 1'b0; evt_miss = 1'b0; evt_conflict = 1'b0; freeze = 1'b0; clear = 1'b0;
    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    nRST = 1'b1;
    @(negedge CLK);

    // T1: counts, then asynchronous reset before the next edge
    run_vectors(0, 8);
    #1 nRST = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // T3 clear collision and T5 protocol error / freeze
    run_vectors(9, 24);

    // T2: 4-bit saturate vs wrap
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0, 0);
    chk("sat4 access at max", {28'd0, s4_acc}, 32'd15);
    chk("sat4 ovf before overflow", {29'd0, s4_ovf}, 32'd0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("sat4 access", {28'd0, s4_acc}, 32'd15);
    chk("sat4 ovf", {29'd0, s4_ovf}, 32'd1);
    chk("wrap4 access", {28'd0, w4_acc}, 32'd1);
    chk("wrap4 ovf", {29'd0, w4_ovf}, 32'd1);

    // T4: snapshot handshake with counting during HOLD
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0);
    chk("t4 ack idle", {31'd0, snap_ack}, 32'd0);
    snap_req = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk("t4 ack", {31'd0, snap_ack}, 32'd1);
    chk("t4 snap_access", snap_access, 32'd10);
    chk("t4 snap_miss", snap_miss, 32'd4);
    chk("t4 snap_conflict", snap_conflict, 32'd1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    chk("t4 hold snap_access", snap_access, 32'd10);
    chk("t4 hold access", access_cnt, 32'd13);
    chk("t4 hold ack", {31'd0, snap_ack}, 32'd1);
    snap_req = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("t4 ack drop", {31'd0, snap_ack}, 32'd0);
    snap_req = 1'b1;
    cyc(0, 0, 0, 0, 1);
    chk("t4 recapture ack", {31'd0, snap_ack}, 32'd1);
    chk("t4 recapture with clear", snap_access, 32'd13);
    chk("t4 cleared live", access_cnt, 32'd0);

    // T6: reset while HOLD, then a fresh capture
    #1 nRST = 1'b0;
    #1 chk("t6 ack", {31'd0, snap_ack}, 32'd0);
    chk("t6 snap_access", snap_access, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    snap_req = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("t6 ack still low", {31'd0, snap_ack}, 32'd0);
    snap_req = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk("t6 fresh ack", {31'd0, snap_ack}, 32'd1);
    chk("t6 fresh snap_access", snap_access, 32'd2);
    snap_req = 1'b0;
    cyc(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
